// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal serial/parallel shift register.
//   shift_dir_e : shift direction encoding (right = LSB-first, left = MSB-first)
//   cnt_width() : width of the bit counter needed to frame a WIDTH-bit word
package shift_reg_pkg;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } shift_dir_e;

    // Number of bits needed to count 0..width-1; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit counter used to frame serial words.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; returns the count to zero
//   inc   : count one accepted bit
//   clr   : restart framing at zero (wins over inc)
//   wrap  : high in the cycle whose inc completes a WIDTH-bit word
module shift_bit_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Explicit wrap so non-power-of-two widths frame correctly.
    assign wrap = inc && !clr && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/shift_reg_universal_sipo.sv
// Universal shift register: serial-in/parallel-out with automatic word framing,
// parallel-load/serial-out, selectable direction, and a valid/ready holding
// register with sticky overrun.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   shift, dir, bit_in : shift enable, direction (0 right / 1 left), serial in
//   load, par_in       : parallel load strobe and data (priority over shift)
//   bit_out            : serial out, end of the register selected by dir
//   sr_out             : live shift register contents
//   word_out           : last framed word
//   word_valid         : framed word pending, consumed with word_ready
//   word_ready         : consumer accept
//   overrun            : sticky, a pending word was overwritten
module shift_reg_universal_sipo
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             dir,
    input  logic             bit_in,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    output logic             bit_out,
    output logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun
);

    if (WIDTH < 2) begin : g_width_check
        $error("shift_reg_universal_sipo: WIDTH must be at least 2");
    end

    shift_dir_e       dir_e;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] sr_right;
    logic [WIDTH-1:0] sr_left;
    logic [WIDTH-1:0] word_out_reg;
    logic             word_valid_reg;
    logic             overrun_reg;
    logic             shift_accept;
    logic             capture;

    assign dir_e        = shift_dir_e'(dir);
    assign shift_accept = shift && !load;

    // Both shifted candidates are built bit by bit; dir picks one.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_right_msb
                assign sr_right[gi] = bit_in;
            end else begin : g_right_mid
                assign sr_right[gi] = sr_reg[gi+1];
            end
            if (gi == 0) begin : g_left_lsb
                assign sr_left[gi] = bit_in;
            end else begin : g_left_mid
                assign sr_left[gi] = sr_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        sr_next = sr_reg;
        if (load) begin
            sr_next = par_in;
        end else if (shift) begin
            sr_next = (dir_e == DIR_LEFT) ? sr_left : sr_right;
        end
    end

    // Load restarts framing, so a loaded word never counts as captured.
    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (shift_accept),
        .clr   (load),
        .wrap  (capture)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg         <= RESET_VAL;
            word_out_reg   <= '0;
            word_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            sr_reg <= sr_next;
            if (capture) begin
                // A capture that coincides with an accept replaces the word
                // cleanly; only an unaccepted pending word counts as overrun.
                word_out_reg   <= sr_next;
                word_valid_reg <= 1'b1;
                if (word_valid_reg && !word_ready) begin
                    overrun_reg <= 1'b1;
                end
            end else if (word_valid_reg && word_ready) begin
                word_valid_reg <= 1'b0;
            end
        end
    end

    assign bit_out    = (dir_e == DIR_LEFT) ? sr_reg[WIDTH-1] : sr_reg[0];
    assign sr_out     = sr_reg;
    assign word_out   = word_out_reg;
    assign word_valid = word_valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_shift_reg_universal_sipo.sv
// Self-checking bench: randomized and directed stimulus, queue-based reference
// model, scoreboard of framed words popped by an independent monitor.
module tb_shift_reg_universal_sipo;
    import shift_reg_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         shift = 1'b0;
    logic         dir = 1'b0;
    logic         bit_in = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] par_in = '0;
    logic         word_ready = 1'b0;
    logic         bit_out;
    logic [W-1:0] sr_out;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overrun;

    int checks = 0;
    int failures = 0;

    // Reference model: register as a bit queue (index 0 = LSB), bits framed
    // since the last word boundary, and the pending-word state.
    bit           m_sr[$];
    int           m_cnt;
    bit           m_valid;
    bit           m_ovr;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;

    always #5 clk = ~clk;

    shift_reg_universal_sipo #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .shift      (shift),
        .dir        (dir),
        .bit_in     (bit_in),
        .load       (load),
        .par_in     (par_in),
        .bit_out    (bit_out),
        .sr_out     (sr_out),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = m_sr[i];
        return r;
    endfunction

    task automatic model_update(input logic rst, input logic l, input logic s,
                                input logic d, input logic b, input logic r,
                                input logic [W-1:0] p);
        bit           accept;
        bit           cap;
        logic [W-1:0] w;
        accept = m_valid && r;
        cap = 1'b0;
        if (rst) begin
            m_sr.delete();
            for (int i = 0; i < W; i++) m_sr.push_back(1'b0);
            m_cnt = 0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            exp_q.delete();
            return;
        end
        if (l) begin
            for (int i = 0; i < W; i++) m_sr[i] = p[i];
            m_cnt = 0;
        end else if (s) begin
            if (d) begin
                void'(m_sr.pop_back());
                m_sr.push_front(b);
            end else begin
                void'(m_sr.pop_front());
                m_sr.push_back(b);
            end
            m_cnt++;
            if (m_cnt == W) begin
                m_cnt = 0;
                cap = 1'b1;
            end
        end
        if (cap) begin
            w = model_word();
            if (m_valid && !accept) begin
                m_ovr = 1'b1;
                if (exp_q.size() > 0) exp_q[exp_q.size()-1] = w;
                else exp_q.push_back(w);
            end else begin
                exp_q.push_back(w);
            end
            m_valid = 1'b1;
        end else if (accept) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock of stimulus: inputs change just after the falling edge, and
    // the model advances on the rising edge that consumes them.
    task automatic step(input logic rst, input logic l, input logic s, input logic d,
                        input logic b, input logic r, input logic [W-1:0] p);
        @(negedge clk);
        #1;
        reset = rst; load = l; shift = s; dir = d; bit_in = b; word_ready = r; par_in = p;
        @(posedge clk);
        model_update(rst, l, s, d, b, r, p);
    endtask

    // Eight shifts of pattern bits pat[0] first; ready high only on the last.
    task automatic shift_word(input logic d, input logic [W-1:0] pat, input logic r_last);
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, d, pat[i], (i == W - 1) ? r_last : 1'b0, '0);
        end
    endtask

    // Monitor: compares live state each cycle and pops the scoreboard on
    // every handshake the model predicts.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("sr_out", sr_out, model_word());
                check("bit_out", {7'b0, bit_out}, {7'b0, (dir ? m_sr[W-1] : m_sr[0])});
                check("word_valid", {7'b0, word_valid}, {7'b0, m_valid});
                check("overrun", {7'b0, overrun}, {7'b0, m_ovr});
                if (m_valid && word_ready && !reset) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty actual=%h required=none", word_out);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer word_out=%h expected=%h", word_out, e);
                        check("word_out", word_out, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] seq;
        pat = 8'h4D;   // bits 1,0,1,1,0,0,1,0 first to last

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check("reset_sr_out", sr_out, 8'h00);
        check("reset_word_out", word_out, 8'h00);
        check("reset_valid", {7'b0, word_valid}, 8'h00);
        mon_en = 1'b1;

        // Right shift, LSB-first framing; valid exactly one edge after 8th shift.
        for (int i = 0; i < W - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, pat[i], 1'b0, '0);
        #1;
        check("right_valid_before_8th", {7'b0, word_valid}, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, pat[W-1], 1'b0, '0);
        #1;
        check("right_word", word_out, 8'h4D);
        check("right_valid", {7'b0, word_valid}, 8'h01);

        // Left shift, MSB-first framing.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        shift_word(1'b1, pat, 1'b0);
        #1;
        check("left_word", word_out, 8'hB2);

        // Partial word, then load restarts framing; serial out of A5.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        #1;
        seq = '0;
        seq[0] = bit_out;
        for (int i = 1; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            #1;
            seq[i] = bit_out;
        end
        check("load_bit_out_seq", seq, 8'hA5);
        check("load_no_early_capture", {7'b0, word_valid}, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check("load_word", word_out, 8'h00);
        check("load_valid", {7'b0, word_valid}, 8'h01);

        // Two words with no accept: overwrite and sticky overrun.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        shift_word(1'b0, pat, 1'b0);
        shift_word(1'b1, pat, 1'b0);
        #1;
        check("ovr_word", word_out, 8'hB2);
        check("ovr_valid", {7'b0, word_valid}, 8'h01);
        check("ovr_flag", {7'b0, overrun}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        #1;
        check("ovr_after_accept_valid", {7'b0, word_valid}, 8'h00);
        check("ovr_sticky", {7'b0, overrun}, 8'h01);

        // Accept coinciding with the capture of the next word.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        shift_word(1'b0, pat, 1'b0);
        shift_word(1'b1, pat, 1'b1);
        #1;
        check("coinc_valid", {7'b0, word_valid}, 8'h01);
        check("coinc_word", word_out, 8'hB2);
        check("coinc_no_ovr", {7'b0, overrun}, 8'h00);

        // Reset mid-word discards partial bits and clears every output.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check("rst_sr_out", sr_out, 8'h00);
        check("rst_word_out", word_out, 8'h00);
        check("rst_outputs", {4'b0, bit_out, word_valid, overrun, 1'b0}, 8'h00);
        shift_word(1'b0, pat, 1'b0);
        #1;
        check("rst_then_word", word_out, 8'h4D);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 200) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                 1'($urandom), 1'($urandom), ($urandom % 3) == 0, W'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
